// File: rtl/snn_axil_cfg_responder_pkg.sv
// Shared constants and FSM state types for the SNN host configuration responder.
// Covers the register map, AXI response codes and the target-field widths.
package snn_cfg_pkg;

    localparam logic [15:0] ADDR_CTRL     = 16'h0000;
    localparam logic [15:0] ADDR_MEM_SEL  = 16'h0004;
    localparam logic [15:0] ADDR_TARGET   = 16'h0008;
    localparam logic [15:0] ADDR_SIM_TIME = 16'h000C;
    localparam logic [15:0] ADDR_STATUS   = 16'h0010;
    localparam logic [15:0] WIN_BASE      = 16'h0100;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int LAYER_W  = 4;
    localparam int NEURON_W = 20;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WIN_WAIT,
        R_RESP
    } rd_state_t;

    // The data window occupies the whole 0x01xx page.
    function automatic logic is_win(input logic [15:0] addr);
        return addr[15:8] == WIN_BASE[15:8];
    endfunction

endpackage

// File: rtl/snn_axil_cfg_responder.sv
// AXI4-Lite responder for the SNN core configuration bus: small register file plus
// a 256-entry window forwarded as single-cycle strobes to the spike/synapse stores.
module snn_axil_cfg_responder
    import snn_cfg_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 16,
    parameter int WIN_RD_TIMEOUT     = 255
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]                      S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg,
    output logic                            net_reset_pulse,
    output logic                            mem_sel,
    output logic [LAYER_W-1:0]              layer_sel,
    output logic [NEURON_W-1:0]             neuron_sel,
    output logic                            target_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   sim_time,
    output logic                            win_wr_en,
    output logic                            win_rd_en,
    output logic [7:0]                      win_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   win_wdata,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   win_rdata,
    input  logic                            win_rd_valid,
    input  logic                            status_busy,
    input  logic                            status_done,
    output logic                            dbg_wr_state,
    output logic [1:0]                      dbg_rd_state
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam logic [8:0] TO_LAST = 9'(WIN_RD_TIMEOUT - 1);

    // Handshakes: a transfer happens on a rising edge where VALID and READY are both
    // high; READY may depend combinationally on VALID, VALID never waits for READY.

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;

    logic [15:0]   aw_a, ar_a;
    logic          wr_accept, rd_accept, rd_wait;
    logic          aw_win, ar_win, aw_rw;
    logic [DW-1:0] ctrl_q, mem_sel_q, target_q, sim_time_q;
    logic [DW-1:0] reg_rdata;
    logic [1:0]    reg_rresp;
    logic [7:0]    rd_idx;
    logic [8:0]    rd_cnt;
    logic          rd_issued;
    logic          unused_ok;

    assign aw_a   = 16'(S_AXI_AWADDR);
    assign ar_a   = 16'(S_AXI_ARADDR);
    assign aw_win = is_win(aw_a);
    assign ar_win = is_win(ar_a);
    assign aw_rw  = aw_a inside {ADDR_CTRL, ADDR_MEM_SEL, ADDR_TARGET, ADDR_SIM_TIME};
    assign unused_ok = ^S_AXI_WSTRB;

    always_comb begin
        reg_rdata = '0;
        reg_rresp = RESP_OKAY;
        case (ar_a)
            ADDR_CTRL:     reg_rdata = ctrl_q;
            ADDR_MEM_SEL:  reg_rdata = mem_sel_q;
            ADDR_TARGET:   reg_rdata = target_q;
            ADDR_SIM_TIME: reg_rdata = sim_time_q;
            ADDR_STATUS:   reg_rdata = {{(DW-2){1'b0}}, status_done, status_busy};
            default:       reg_rresp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next       = w_state;
        wr_accept    = 1'b0;
        S_AXI_BVALID = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    wr_accept = 1'b1;
                    w_next    = W_RESP;
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign S_AXI_AWREADY = wr_accept;
    assign S_AXI_WREADY  = wr_accept;
    assign win_wr_en     = wr_accept && aw_win;

    // A pending window read yields the shared port to a write issued the same cycle.
    always_comb begin
        r_next       = r_state;
        rd_accept    = 1'b0;
        rd_wait      = 1'b0;
        win_rd_en    = 1'b0;
        S_AXI_RVALID = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    rd_accept = 1'b1;
                    r_next    = ar_win ? R_WIN_WAIT : R_RESP;
                end
            end
            R_WIN_WAIT: begin
                win_rd_en = !rd_issued && !win_wr_en;
                rd_wait   = rd_issued || win_rd_en;
                if (rd_wait && (win_rd_valid || rd_cnt == TO_LAST)) r_next = R_RESP;
            end
            R_RESP: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign S_AXI_ARREADY = rd_accept;
    assign win_addr      = win_wr_en ? aw_a[7:0] : (win_rd_en ? rd_idx : 8'h00);
    assign win_wdata     = win_wr_en ? S_AXI_WDATA : '0;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_q          <= '0;
            mem_sel_q       <= '0;
            target_q        <= '0;
            sim_time_q      <= '0;
            net_reset_pulse <= 1'b0;
            S_AXI_BRESP     <= RESP_OKAY;
            S_AXI_RDATA     <= '0;
            S_AXI_RRESP     <= RESP_OKAY;
            rd_idx          <= '0;
            rd_cnt          <= '0;
            rd_issued       <= 1'b0;
        end else begin
            net_reset_pulse <= 1'b0;
            if (wr_accept) begin
                S_AXI_BRESP <= (aw_win || aw_rw) ? RESP_OKAY : RESP_SLVERR;
                case (aw_a)
                    ADDR_CTRL: begin
                        ctrl_q          <= S_AXI_WDATA;
                        net_reset_pulse <= S_AXI_WDATA[0];
                    end
                    ADDR_MEM_SEL:  mem_sel_q  <= S_AXI_WDATA;
                    ADDR_TARGET:   target_q   <= S_AXI_WDATA;
                    ADDR_SIM_TIME: sim_time_q <= S_AXI_WDATA;
                    default: ;
                endcase
            end
            // Register reads sample here, so a same-edge write is not yet visible.
            if (rd_accept) begin
                rd_idx    <= ar_a[7:0];
                rd_cnt    <= '0;
                rd_issued <= 1'b0;
                if (!ar_win) begin
                    S_AXI_RDATA <= reg_rdata;
                    S_AXI_RRESP <= reg_rresp;
                end
            end
            if (win_rd_en) rd_issued <= 1'b1;
            if (rd_wait) begin
                if (win_rd_valid) begin
                    S_AXI_RDATA <= win_rdata;
                    S_AXI_RRESP <= RESP_OKAY;
                end else if (rd_cnt == TO_LAST) begin
                    S_AXI_RDATA <= '0;
                    S_AXI_RRESP <= RESP_SLVERR;
                end else begin
                    rd_cnt <= rd_cnt + 9'd1;
                end
            end
        end
    end

    assign ctrl_reg     = ctrl_q;
    assign mem_sel      = mem_sel_q[0];
    assign layer_sel    = target_q[31:28];
    assign neuron_sel   = target_q[27:8];
    assign target_valid = target_q[0];
    assign sim_time     = sim_time_q;
    assign dbg_wr_state = w_state;
    assign dbg_rd_state = r_state;

endmodule

// File: tb/tb_snn_axil_cfg_responder.sv
// Bench for snn_axil_cfg_responder: directed register/window cases plus randomized
// traffic scored against a register/window model held in plain variables.
`timescale 1ns/1ps
module tb_snn_axil_cfg_responder;
    import snn_cfg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] awaddr = '0, araddr = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;
    logic [31:0] ctrl_reg, sim_time, win_wdata, win_rdata;
    logic        net_reset_pulse, mem_sel, target_valid, win_wr_en, win_rd_en, win_rd_valid;
    logic [3:0]  layer_sel;
    logic [19:0] neuron_sel;
    logic [7:0]  win_addr;
    logic        status_busy = 0, status_done = 0;
    logic        dbg_wr_state;
    logic [1:0]  dbg_rd_state;

    snn_axil_cfg_responder dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .ctrl_reg(ctrl_reg), .net_reset_pulse(net_reset_pulse), .mem_sel(mem_sel),
        .layer_sel(layer_sel), .neuron_sel(neuron_sel), .target_valid(target_valid),
        .sim_time(sim_time), .win_wr_en(win_wr_en), .win_rd_en(win_rd_en),
        .win_addr(win_addr), .win_wdata(win_wdata), .win_rdata(win_rdata),
        .win_rd_valid(win_rd_valid), .status_busy(status_busy), .status_done(status_done),
        .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    int          n_checks = 0, n_errors = 0;
    logic [31:0] m_ctrl = 0, m_mem = 0, m_tgt = 0, m_sim = 0;
    logic [31:0] exp_win [256];
    int          exp_pulses = 0;
    logic [33:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] model_write(input logic [15:0] a, input logic [31:0] d);
        if (a[15:8] == 8'h01) begin
            exp_win[a[7:0]] = d;
            return 2'b00;
        end
        case (a)
            16'h0000: begin m_ctrl = d; if (d[0]) exp_pulses++; end
            16'h0004: m_mem = d;
            16'h0008: m_tgt = d;
            16'h000C: m_sim = d;
            default:  return 2'b10;
        endcase
        return 2'b00;
    endfunction

    function automatic logic [33:0] model_read(input logic [15:0] a);
        if (a[15:8] == 8'h01) return {2'b00, exp_win[a[7:0]]};
        case (a)
            16'h0000: return {2'b00, m_ctrl};
            16'h0004: return {2'b00, m_mem};
            16'h0008: return {2'b00, m_tgt};
            16'h000C: return {2'b00, m_sim};
            16'h0010: return {2'b00, 30'b0, status_done, status_busy};
            default:  return {2'b10, 32'b0};
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, "_ctrl"}, ctrl_reg, m_ctrl);
        check_eq({tag, "_mem_sel"}, {31'b0, mem_sel}, {31'b0, m_mem[0]});
        check_eq({tag, "_layer"}, {28'b0, layer_sel}, {28'b0, m_tgt[31:28]});
        check_eq({tag, "_neuron"}, {12'b0, neuron_sel}, {12'b0, m_tgt[27:8]});
        check_eq({tag, "_tvalid"}, {31'b0, target_valid}, {31'b0, m_tgt[0]});
        check_eq({tag, "_sim_time"}, sim_time, m_sim);
    endtask

    // ---------------- window store and strobe monitor ----------------
    logic [31:0] win_mem [256];
    int          cyc = 0, wr_strobes = 0, rd_strobes = 0, overlaps = 0, pulses = 0;
    int          last_wr_cyc = 0, last_rd_cyc = 0, rv_cyc = 0;
    logic [7:0]  last_wr_addr = 0;
    logic [31:0] last_wr_data = 0;
    logic        rsp_silent = 0;
    int          rsp_delay_cfg = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            if (win_wr_en) begin
                wr_strobes++; last_wr_cyc = cyc; last_wr_addr = win_addr; last_wr_data = win_wdata;
            end
            if (win_rd_en) begin rd_strobes++; last_rd_cyc = cyc; end
            if (win_wr_en && win_rd_en) overlaps++;
            if (net_reset_pulse) pulses++;
        end
    end

    initial begin
        logic       pend;
        logic [7:0] paddr;
        int         remain;
        pend = 0; paddr = 0; remain = 0;
        win_rd_valid = 0; win_rdata = 0;
        forever begin
            @(negedge clk);
            win_rd_valid = 0; win_rdata = 0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (win_wr_en) win_mem[win_addr] = win_wdata;
                if (pend) begin
                    remain--;
                    if (remain == 0) begin
                        win_rd_valid = 1; win_rdata = win_mem[paddr]; pend = 0;
                    end
                end
                if (win_rd_en && !rsp_silent) begin
                    pend = 1; paddr = win_addr;
                    remain = (rsp_delay_cfg != 0) ? rsp_delay_cfg : int'($urandom_range(1, 6));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, output logic [1:0] resp);
        int t;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = 4'($urandom_range(0, 15)); awvalid = 1; wvalid = 1;
        @(negedge clk);
        t = 0;
        while (!awready && t < 50) begin @(negedge clk); t++; end
        check_eq("aw_handshake", {31'b0, awready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; bready = 1;
        @(negedge clk);
        t = 0;
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        check_eq("bvalid_seen", {31'b0, bvalid}, 32'd1);
        resp = bresp;
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp);
        int t;
        @(posedge clk); #1;
        araddr = a; arvalid = 1;
        @(negedge clk);
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        check_eq("ar_handshake", {31'b0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 0; rready = 1;
        @(negedge clk);
        t = 0;
        while (!rvalid && t < 400) begin @(negedge clk); t++; end
        check_eq("rvalid_seen", {31'b0, rvalid}, 32'd1);
        d = rdata; resp = rresp; rv_cyc = cyc;
        @(posedge clk); #1;
        rready = 0;
    endtask

    task automatic read_expect(input string tag, input logic [15:0] a);
        logic [31:0] d;
        logic [1:0]  r;
        logic [33:0] e;
        exp_q.push_back(model_read(a));
        axi_read(a, d, r);
        e = exp_q.pop_front();
        check_eq({tag, "_rdata"}, d, e[31:0]);
        check_eq({tag, "_rresp"}, {30'b0, r}, {30'b0, e[33:32]});
    endtask

    task automatic write_expect(input string tag, input logic [15:0] a, input logic [31:0] d);
        logic [1:0] r, e;
        e = model_write(a, d);
        axi_write(a, d, r);
        check_eq({tag, "_bresp"}, {30'b0, r}, {30'b0, e});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] d, old_ctrl, tval;
        logic [1:0]  r, r2;
        logic [15:0] a;
        int          wr_before, n_idx;

        for (int i = 0; i < 256; i++) begin exp_win[i] = 0; win_mem[i] = 0; end
        repeat (3) @(negedge clk);
        check_eq("reset_ctrl", ctrl_reg, 32'd0);
        check_eq("reset_flags", {26'b0, bvalid, rvalid, awready, arready, win_wr_en, win_rd_en},
                 32'd0);
        @(posedge clk); #1 rst_n = 1;

        read_expect("rd_ctrl_init", ADDR_CTRL);
        write_expect("wr_ctrl", ADDR_CTRL, 32'hDEADBEEF);
        read_expect("rd_ctrl", ADDR_CTRL);
        check_eq("pulse_count_1", pulses, exp_pulses);

        write_expect("wr_mem_sel", ADDR_MEM_SEL, 32'h1);
        write_expect("wr_target", ADDR_TARGET, 32'h1 | (32'd3 << 8) | (32'd1 << 28));
        write_expect("wr_sim", ADDR_SIM_TIME, 32'h0000_1234);
        check_outputs("cfg");

        wr_before = wr_strobes;
        write_expect("wr_win", 16'h0103, 32'h1C71C71C);
        check_eq("win_wr_count", wr_strobes - wr_before, 32'd1);
        check_eq("win_wr_addr", {24'b0, last_wr_addr}, 32'h03);
        check_eq("win_wr_data", last_wr_data, 32'h1C71C71C);

        win_mem[5] = 32'h55; exp_win[5] = 32'h55; rsp_delay_cfg = 3;
        read_expect("rd_win_d3", 16'h0105);
        rsp_delay_cfg = 0;
        rsp_silent = 1;
        axi_read(16'h0105, d, r);
        check_eq("win_to_rdata", d, 32'd0);
        check_eq("win_to_rresp", {30'b0, r}, 32'd2);
        check_eq("win_to_cycles", rv_cyc - last_rd_cyc, 32'd255);
        rsp_silent = 0;

        write_expect("wr_status", ADDR_STATUS, 32'hFFFF_FFFF);
        write_expect("wr_unmapped", 16'h0040, 32'hFFFF_FFFF);
        check_outputs("after_slverr");
        read_expect("rd_unmapped", 16'h0040);
        status_busy = 1; status_done = 0;
        read_expect("rd_status", ADDR_STATUS);
        read_expect("rd_target", ADDR_TARGET);

        // BREADY held low: the second write must stall behind the pending response.
        @(posedge clk); #1;
        awaddr = ADDR_SIM_TIME; wdata = 32'hCAFE_0001; awvalid = 1; wvalid = 1; bready = 0;
        @(negedge clk);
        check_eq("hold_first_aw", {31'b0, awready}, 32'd1);
        void'(model_write(ADDR_SIM_TIME, 32'hCAFE_0001));
        @(posedge clk); #1;
        awaddr = ADDR_CTRL; wdata = 32'h0000_0002;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_bvalid", {31'b0, bvalid}, 32'd1);
            check_eq("hold_awready", {31'b0, awready}, 32'd0);
        end
        @(posedge clk); #1 awvalid = 0; wvalid = 0; bready = 1;
        @(posedge clk); #1 bready = 0;
        check_outputs("after_hold");

        // Same-cycle register write and read: read sees the old CTRL value.
        old_ctrl = m_ctrl;
        tval = 32'h1234_5670;
        void'(model_write(ADDR_CTRL, tval));
        fork
            axi_write(ADDR_CTRL, tval, r2);
            axi_read(ADDR_CTRL, d, r);
        join
        check_eq("simul_rdata", d, old_ctrl);
        check_eq("simul_bresp", {30'b0, r2}, 32'd0);
        check_eq("simul_ctrl_after", ctrl_reg, tval);

        // A window write landing on the read-issue cycle takes the port first.
        exp_q.push_back(model_read(16'h0120));
        void'(model_write(16'h0130, 32'hA5A5_0130));
        fork
            axi_read(16'h0120, d, r);
            begin @(posedge clk); axi_write(16'h0130, 32'hA5A5_0130, r2); end
        join
        begin
            logic [33:0] e;
            e = exp_q.pop_front();
            check_eq("arb_rdata", d, e[31:0]);
        end
        check_eq("arb_rd_after_wr", last_rd_cyc - last_wr_cyc, 32'd1);

        // Randomized mixed traffic.
        for (int k = 0; k < 80; k++) begin
            status_busy = 1'($urandom_range(0, 1));
            status_done = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: a = ADDR_CTRL;
                1: a = ADDR_MEM_SEL;
                2: a = ADDR_TARGET;
                3: a = ADDR_SIM_TIME;
                4: a = ADDR_STATUS;
                5: a = 16'($urandom_range(16'h0200, 16'hFFFF));
                default: begin
                    n_idx = int'($urandom_range(0, 255));
                    a = 16'h0100 + 16'(n_idx);
                end
            endcase
            if ($urandom_range(0, 1) == 1) write_expect("rnd_wr", a, $urandom);
            else read_expect("rnd_rd", a);
        end
        check_outputs("rnd");

        // Reset while a window read is stalled.
        rsp_silent = 1;
        @(posedge clk); #1 araddr = 16'h01AA; arvalid = 1;
        @(posedge clk); #1 arvalid = 0;
        repeat (10) @(negedge clk);
        check_eq("rst_in_wait_state", {30'b0, dbg_rd_state}, {30'b0, R_WIN_WAIT});
        rst_n = 0;
        #1;
        m_ctrl = 0; m_mem = 0; m_tgt = 0; m_sim = 0;
        check_outputs("rst_async");
        check_eq("rst_axi", {rdata[15:0], 8'b0, bresp, rresp, bvalid, rvalid, arready, awready},
                 32'd0);
        check_eq("rst_win", {win_wdata[15:0], win_addr, 5'b0, win_wr_en, win_rd_en,
                 net_reset_pulse}, 32'd0);
        @(posedge clk); #1 rst_n = 1; rsp_silent = 0;
        read_expect("post_rst_win", 16'h01AA);
        read_expect("post_rst_target", ADDR_TARGET);

        check_eq("no_port_overlap", overlaps, 32'd0);
        check_eq("pulse_count_final", pulses, exp_pulses);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
